// File: rtl/ram_word_port_if.sv
// Word request/response channel between a 32-bit requester and ram_word_port.
// Signals:
//   req_valid/req_ready  request handshake
//   req_write            1 = write, 0 = read
//   req_addr             byte address (bits [1:0] ignored by the port)
//   req_wdata/req_wstrb  little-endian write word and per-byte enables
//   resp_valid/ready     response handshake
//   resp_rdata           read word, 0 for write acks
interface ram_word_port_if #(
   parameter int unsigned ADDR_WIDTH = 10
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic [3:0]            req_wstrb;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [31:0]           resp_rdata;

   // Requester side
   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid, resp_rdata
   );

   // Port side
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/ram_word_port.sv
// Drives a byte-wide negedge synchronous RAM on behalf of a 32-bit requester.
// Each word request becomes four byte beats at base*4+0..3; reads are assembled
// little-endian and returned on the response channel, writes are acked with 0.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   bus (slave)           word request/response channel
//   o_ram_addr            RAM byte address (registered)
//   o_ram_data_in         RAM write data (registered)
//   o_ram_write_enable    RAM write enable (registered)
//   i_ram_data_out        RAM read data, valid one cycle after the address
module ram_word_port #(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ram_word_port_if.slave        bus,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic [7:0]            o_ram_data_in,
   output logic                  o_ram_write_enable,
   input  logic [7:0]            i_ram_data_out
);

   localparam int unsigned BASE_W = ADDR_WIDTH - 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t                r_state, w_state_n;
   logic [1:0]            r_cnt, w_cnt_n, w_cnt_inc;
   logic [BASE_W-1:0]     r_base, w_base_n;
   logic [31:0]           r_wdata, w_wdata_n;
   logic [3:0]            r_wstrb, w_wstrb_n;
   logic [23:0]           r_rbuf, w_rbuf_n;
   logic                  r_req_ready, w_req_ready_n;
   logic                  r_resp_valid, w_resp_valid_n;
   logic [31:0]           r_resp_rdata, w_resp_rdata_n;
   logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr_n;
   logic [7:0]            r_ram_din, w_ram_din_n;
   logic                  r_ram_we, w_ram_we_n;

   // Word-aligned port: the byte offset of the request address is discarded
   logic w_unused_addr_lsb;
   assign w_unused_addr_lsb = ^bus.req_addr[1:0];

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cnt        <= 2'd0;
         r_base       <= '0;
         r_wdata      <= 32'd0;
         r_wstrb      <= 4'd0;
         r_rbuf       <= 24'd0;
         r_req_ready  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_ram_addr   <= '0;
         r_ram_din    <= 8'd0;
         r_ram_we     <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_cnt        <= w_cnt_n;
         r_base       <= w_base_n;
         r_wdata      <= w_wdata_n;
         r_wstrb      <= w_wstrb_n;
         r_rbuf       <= w_rbuf_n;
         r_req_ready  <= w_req_ready_n;
         r_resp_valid <= w_resp_valid_n;
         r_resp_rdata <= w_resp_rdata_n;
         r_ram_addr   <= w_ram_addr_n;
         r_ram_din    <= w_ram_din_n;
         r_ram_we     <= w_ram_we_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_n      = r_state;
      w_cnt_n        = r_cnt;
      w_base_n       = r_base;
      w_wdata_n      = r_wdata;
      w_wstrb_n      = r_wstrb;
      w_rbuf_n       = r_rbuf;
      w_req_ready_n  = r_req_ready;
      w_resp_valid_n = r_resp_valid;
      w_resp_rdata_n = r_resp_rdata;
      w_ram_addr_n   = r_ram_addr;
      w_ram_din_n    = r_ram_din;
      w_ram_we_n     = r_ram_we;
      w_cnt_inc      = r_cnt + 2'd1;

      case (r_state)
         IDLE: begin
            w_req_ready_n = 1'b1;
            // r_req_ready gates acceptance so the first edge after reset only raises ready
            if (bus.req_valid && r_req_ready) begin
               w_base_n      = bus.req_addr[ADDR_WIDTH-1:2];
               w_wdata_n     = bus.req_wdata;
               w_wstrb_n     = bus.req_wstrb;
               w_cnt_n       = 2'd0;
               w_req_ready_n = 1'b0;
               w_ram_addr_n  = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
               if (bus.req_write) begin
                  w_state_n   = WR;
                  w_ram_din_n = bus.req_wdata[7:0];
                  w_ram_we_n  = bus.req_wstrb[0];
               end else begin
                  w_state_n  = RD;
                  w_ram_we_n = 1'b0;
               end
            end
         end

         WR: begin
            if (r_cnt == 2'd3) begin
               w_ram_we_n     = 1'b0;
               w_resp_rdata_n = 32'd0;
               w_resp_valid_n = 1'b1;
               w_state_n      = RESP;
            end else begin
               // Every beat takes a cycle; a cleared strobe only suppresses the enable
               w_cnt_n      = w_cnt_inc;
               w_ram_addr_n = {r_base, w_cnt_inc};
               w_ram_din_n  = r_wdata[{w_cnt_inc, 3'b000} +: 8];
               w_ram_we_n   = r_wstrb[w_cnt_inc];
            end
         end

         RD: begin
            w_ram_we_n = 1'b0;
            // Data present now belongs to the address driven one edge earlier
            if (r_cnt == 2'd3) begin
               w_resp_rdata_n = {i_ram_data_out, r_rbuf};
               w_resp_valid_n = 1'b1;
               w_state_n      = RESP;
            end else begin
               w_rbuf_n[{r_cnt, 3'b000} +: 8] = i_ram_data_out;
               w_cnt_n      = w_cnt_inc;
               w_ram_addr_n = {r_base, w_cnt_inc};
            end
         end

         RESP: begin
            if (bus.resp_ready) begin
               w_resp_valid_n = 1'b0;
               w_req_ready_n  = 1'b1;
               w_state_n      = IDLE;
            end
         end

         default: w_state_n = IDLE;
      endcase
   end

   assign bus.req_ready      = r_req_ready;
   assign bus.resp_valid     = r_resp_valid;
   assign bus.resp_rdata     = r_resp_rdata;
   assign o_ram_addr         = r_ram_addr;
   assign o_ram_data_in      = r_ram_din;
   assign o_ram_write_enable = r_ram_we;

endmodule

// File: tb/tb_ram_word_port.sv
// Self-checking bench for ram_word_port: byte RAM model on the RAM side,
// word-level reference memory for expected read data and RAM contents.
module tb_ram_word_port;

   localparam int unsigned AW  = 10;
   localparam int unsigned MEM = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_din;
   logic [7:0]    ram_dout;
   logic          ram_we;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]    ram     [0:MEM-1];
   logic [7:0]    ref_mem [0:MEM-1];
   logic          tr_we   [0:3];
   logic [AW-1:0] tr_addr [0:3];

   always #5 clk = ~clk;

   ram_word_port_if #(.ADDR_WIDTH(AW)) bus ();

   ram_word_port #(.ADDR_WIDTH(AW)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .bus                (bus.slave),
      .o_ram_addr         (ram_addr),
      .o_ram_data_in      (ram_din),
      .o_ram_write_enable (ram_we),
      .i_ram_data_out     (ram_dout)
   );

   // Byte RAM: negedge write, negedge registered read
   always @(negedge clk) begin
      if (ram_we === 1'b1) ram[ram_addr] <= ram_din;
      ram_dout <= ram[ram_addr];
   end

   function automatic int word_base(input logic [AW-1:0] a);
      return (int'(a) / 4) * 4;
   endfunction

   function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
      int b;
      b = word_base(a);
      return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
   endfunction

   function automatic logic [31:0] ram_word(input logic [AW-1:0] a);
      int b;
      b = word_base(a);
      return {ram[b+3], ram[b+2], ram[b+1], ram[b]};
   endfunction

   task automatic ref_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      int b;
      b = word_base(a);
      for (int k = 0; k < 4; k++)
         if (s[k]) ref_mem[b+k] = d[8*k +: 8];
   endtask

   // Issues one request, traces beats, waits for the response; consumes it if resp_ready is high
   task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rdata, output int lat);
      int g;
      g = 0;
      while (bus.req_ready !== 1'b1 && g < 20) begin
         @(posedge clk); #1; g++;
      end
      n_checks++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL req_ready_wait: req_ready=%b required 1", bus.req_ready);
      end
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_wstrb = s;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_wdata = $urandom;
      tr_we[0]   = ram_we;
      tr_addr[0] = ram_addr;
      lat = 0;
      while (lat < 16) begin
         @(posedge clk); #1;
         lat++;
         if (lat <= 3) begin
            tr_we[lat]   = ram_we;
            tr_addr[lat] = ram_addr;
         end
         if (bus.resp_valid === 1'b1) break;
      end
      rdata = bus.resp_rdata;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = 32'd0;
      bus.req_wstrb  = 4'd0;
      bus.resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.req_ready, bus.resp_valid, ram_we} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ctrl: ready/valid/we=%b required 000", {bus.req_ready, bus.resp_valid, ram_we});
      end
      n_checks++;
      if ({bus.resp_rdata, ram_addr, ram_din} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: rdata=%h addr=%h din=%h required 0", bus.resp_rdata, ram_addr, ram_din);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (bus.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_ready: req_ready=%b required 0 before first edge", bus.req_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_edge_ready: req_ready=%b required 1", bus.req_ready);
      end
   endtask

   task automatic test_full_write_read();
      logic [31:0] rd;
      int lat;
      do_req(1'b1, AW'('h010), 32'hDEADBEEF, 4'hF, rd, lat);
      ref_write(AW'('h010), 32'hDEADBEEF, 4'hF);
      n_checks++;
      if (lat !== 4 || rd !== 32'd0) begin
         n_fail++;
         $display("FAIL full_write_resp: lat=%0d rdata=%h required 4 / 0", lat, rd);
      end
      n_checks++;
      if (ram_word(AW'('h010)) !== ref_read(AW'('h010))) begin
         n_fail++;
         $display("FAIL full_write_ram: ram=%h required %h", ram_word(AW'('h010)), ref_read(AW'('h010)));
      end
      do_req(1'b0, AW'('h010), 32'd0, 4'h0, rd, lat);
      n_checks++;
      if (lat !== 4 || rd !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL full_read: lat=%0d rdata=%h required 4 / deadbeef", lat, rd);
      end
   endtask

   task automatic test_partial_strobe();
      logic [31:0] rd;
      int lat;
      do_req(1'b1, AW'('h010), 32'h11223344, 4'h5, rd, lat);
      ref_write(AW'('h010), 32'h11223344, 4'h5);
      n_checks++;
      if ({tr_we[3], tr_we[2], tr_we[1], tr_we[0]} !== 4'b0101) begin
         n_fail++;
         $display("FAIL partial_we_beats: we=%b required 0101", {tr_we[3], tr_we[2], tr_we[1], tr_we[0]});
      end
      do_req(1'b0, AW'('h010), 32'd0, 4'h0, rd, lat);
      n_checks++;
      if (rd !== ref_read(AW'('h010)) || rd !== 32'hDE22BE44) begin
         n_fail++;
         $display("FAIL partial_read: rdata=%h required de22be44", rd);
      end
   endtask

   task automatic test_alignment();
      logic [31:0] rd;
      int lat;
      do_req(1'b0, AW'('h013), 32'd0, 4'h0, rd, lat);
      n_checks++;
      if (rd !== ref_read(AW'('h010))) begin
         n_fail++;
         $display("FAIL align_read_013: rdata=%h required %h", rd, ref_read(AW'('h010)));
      end
      do_req(1'b1, AW'('h3FC), 32'hCAFEF00D, 4'hF, rd, lat);
      ref_write(AW'('h3FC), 32'hCAFEF00D, 4'hF);
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (tr_addr[k] !== AW'(32'h3FC + k)) begin
            n_fail++;
            $display("FAIL top_beat_addr%0d: addr=%h required %h", k, tr_addr[k], 32'h3FC + k);
         end
      end
      do_req(1'b0, AW'('h3FE), 32'd0, 4'h0, rd, lat);
      n_checks++;
      if (rd !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL top_read: rdata=%h required cafef00d", rd);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd;
      logic [31:0] exp;
      int lat;
      exp = ref_read(AW'('h3FC));
      bus.resp_ready = 1'b0;
      do_req(1'b0, AW'('h3FC), 32'd0, 4'h0, rd, lat);
      n_checks++;
      if (lat !== 4 || rd !== exp) begin
         n_fail++;
         $display("FAIL bp_read: lat=%0d rdata=%h required 4 / %h", lat, rd, exp);
      end
      // A competing write must not be taken while the response is pending
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = AW'('h3FC);
      bus.req_wdata = 32'h0;
      bus.req_wstrb = 4'hF;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold%0d: valid=%b rdata=%h ready=%b required 1/%h/0",
                     c, bus.resp_valid, bus.resp_rdata, bus.req_ready, exp);
         end
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: ready=%b valid=%b required 1/0", bus.req_ready, bus.resp_valid);
      end
      n_checks++;
      if (ram_word(AW'('h3FC)) !== exp) begin
         n_fail++;
         $display("FAIL bp_no_write: ram=%h required %h", ram_word(AW'('h3FC)), exp);
      end
   endtask

   task automatic test_reset_mid_write();
      int g;
      g = 0;
      while (bus.req_ready !== 1'b1 && g < 20) begin
         @(posedge clk); #1; g++;
      end
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = AW'('h020);
      bus.req_wdata = 32'hAABBCCDD;
      bus.req_wstrb = 4'hF;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (ram_we !== 1'b0 || bus.resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midwr_reset_we: we=%b valid=%b required 0/0", ram_we, bus.resp_valid);
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if (bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midwr_no_resp%0d: valid=%b required 0", c, bus.resp_valid);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      ref_mem[32'h20] = 8'hDD;
      ref_mem[32'h21] = 8'hCC;
      n_checks++;
      if (ram_word(AW'('h020)) !== ref_read(AW'('h020)) || ram_word(AW'('h020)) !== 32'h0000CCDD) begin
         n_fail++;
         $display("FAIL midwr_ram: ram=%h required 0000ccdd", ram_word(AW'('h020)));
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midwr_ready_after: req_ready=%b required 1", bus.req_ready);
      end
   endtask

   task automatic test_random();
      logic [31:0]   rd, d;
      logic [AW-1:0] a;
      logic [3:0]    s;
      logic          w;
      int            lat, b;
      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom_range(0, 1));
         a = AW'($urandom_range(0, MEM - 1));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         b = word_base(a);
         do_req(w, a, d, s, rd, lat);
         n_checks++;
         if (lat !== 4) begin
            n_fail++;
            $display("FAIL rnd%0d_latency: lat=%0d required 4", i, lat);
         end
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (tr_addr[k] !== AW'(b + k) || tr_we[k] !== (w & s[k])) begin
               n_fail++;
               $display("FAIL rnd%0d_beat%0d: addr=%h we=%b required %h/%b",
                        i, k, tr_addr[k], tr_we[k], b + k, w & s[k]);
            end
         end
         if (w) begin
            ref_write(a, d, s);
            n_checks++;
            if (rd !== 32'd0 || ram_word(a) !== ref_read(a)) begin
               n_fail++;
               $display("FAIL rnd%0d_write: rdata=%h ram=%h required 0/%h", i, rd, ram_word(a), ref_read(a));
            end
         end else begin
            n_checks++;
            if (rd !== ref_read(a)) begin
               n_fail++;
               $display("FAIL rnd%0d_read: rdata=%h required %h", i, rd, ref_read(a));
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < int'(MEM); i++) begin
         ram[i]     = 8'h00;
         ref_mem[i] = 8'h00;
      end
      test_reset();
      test_full_write_read();
      test_partial_strobe();
      test_alignment();
      test_backpressure();
      test_reset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_word_port.md
# ram_word_port

Initiator-side port that drives a byte-wide synchronous RAM (negedge read/write, one-cycle registered read data) on behalf of a 32-bit requester. Accepts word read/write requests over a valid/ready handshake, sequences four byte beats on the RAM port with per-byte write strobes, and assembles little-endian read words. Sits between the core/cache logic and each byte-wide RAM instance.

## Interface

- ADDR_WIDTH, 10, RAM byte-address width; word space is 2**(ADDR_WIDTH-2) words.
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  port can accept a request (registered).
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- req_wdata  in  32  write data, byte n in bits [8n+7:8n].
- req_wstrb  in  4  per-byte write enables.
- resp_valid  out  1  response present (read data or write ack).
- resp_ready  in  1  requester accepts response.
- resp_rdata  out  32  read word; 0 for write acks.
- ram_addr  out  ADDR_WIDTH  RAM byte address.
- ram_data_in  out  8  RAM write data.
- ram_write_enable  out  1  RAM write enable.
- ram_data_out  in  8  RAM read data.

## Operation

- States: IDLE, WR, RD, RESP. 2-bit beat counter cnt. Latched base = req_addr[ADDR_WIDTH-1:2], wdata, wstrb.
- IDLE: req_ready=1. Accept on posedge with req_valid && req_ready; latch request, cnt=0, go WR or RD; drive beat 0 on the same edge.
- RAM-side outputs registered; ram_addr = {base, cnt}; RAM commits/reads at the following negedge.
- WR: per edge drive ram_data_in = wdata[8cnt+7:8cnt], ram_write_enable = wstrb[cnt]. Every beat takes one cycle even if its strobe is 0. On the edge ending cnt==3: ram_write_enable=0, resp_rdata=0, go RESP.
- RD: ram_write_enable=0. Each edge in RD captures ram_data_out into byte cnt of the read buffer; if cnt<3, cnt++ and ram_addr advances; if cnt==3, resp_rdata = assembled word, go RESP.
- RESP: resp_valid=1, resp_rdata stable. On resp_valid && resp_ready edge: resp_valid=0, req_ready=1, go IDLE. No new request accepted in that same edge.
- req_ready = 1 only in IDLE; registered, set on the edge entering IDLE.
- req_valid while not ready: ignored; inputs need not be held by the port.
- Addresses never cross a word; beat addresses are base*4+0..3, no wrap into the next word.

## Timing

- Reset (rst_n low, async): state IDLE, cnt=0, req_ready=0, resp_valid=0, resp_rdata=0, ram_addr=0, ram_data_in=0, ram_write_enable=0. req_ready rises on the first posedge with rst_n high.
- Accept edge E0 drives beat 0; beats 1-3 on E1-E3; E4 enters RESP with resp_valid=1. Latency from accept edge to resp_valid is 4 cycles for both reads and writes.
- Read capture: byte n sampled on edge E(n+1), relying on the RAM's negedge read of the address presented at E(n).
- Minimum request-to-request spacing: 6 cycles (accept, 3 beats, RESP with resp_ready=1, IDLE).
- Reset mid-write: ram_write_enable drops immediately. Bytes committed at earlier negedges stay written; later beats are not performed. No response is generated.
- Reset mid-read or in RESP: the response is discarded.

## Test plan

- Reset: hold rst_n low 3 cycles -> all outputs 0, req_ready 0. Release -> req_ready=1 after first posedge.
- Full write then read: write 0xDEADBEEF to 0x010, wstrb 0xF -> RAM[0x10..0x13] = EF,BE,AD,DE; resp_valid 4 cycles after accept, resp_rdata=0. Read 0x010 -> resp_rdata 0xDEADBEEF after 4 cycles.
- Partial strobe: write 0x11223344 to 0x010 with wstrb 0x5 -> read returns 0xDE22BE44. ram_write_enable is low on beats 1 and 3.
- Address alignment/top of memory:
  - read 0x013 returns the same word as 0x010;
  - write 0xCAFEF00D to 0x3FC, then read it back -> 0xCAFEF00D;
  - ram_addr never exceeds 0x3FF.
- Backpressure: hold resp_ready low 5 cycles after a read -> resp_valid and resp_rdata stable, req_ready 0, a concurrent req_valid is not accepted. Raise resp_ready -> req_ready=1 next cycle.
- Reset mid-write: write 0xAABBCCDD to 0x020 (prior 0), assert rst_n low after beat 1's negedge -> ram_write_enable 0 at once, RAM[0x20..0x23] = DD,CC,00,00, no resp_valid.
